// File: rtl/RVS192_user_parameters.sv
// rtl/RVS192_user_parameters.sv - core-wide address split shared by the L1 memory blocks
package RVS192_user_parameters;

    localparam int BYTE_OFFSET = 2;
    localparam int WORD_OFFSET = 4;

endpackage

// File: rtl/l1_evict_buffer_pkg.sv
// rtl/l1_evict_buffer_pkg.sv - sizes, drain FSM states and entry layout for the L1 evict buffer
package l1_evict_buffer_pkg;
    import RVS192_user_parameters::*;

    localparam int SLOT         = 4;
    localparam int DATA_LENGTH  = 32;
    localparam int ADDR_LENGTH  = 32;
    localparam int LINE_OFFSET  = BYTE_OFFSET + WORD_OFFSET;
    // derived so the tag always spans exactly the bits above the line offset
    localparam int VCTAG_LENGTH = ADDR_LENGTH - LINE_OFFSET;
    localparam int BUF_DEPTH    = 4;
    localparam int LINE_W       = SLOT * DATA_LENGTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WB_REQ  = 2'd1,
        VC_FILL = 2'd2
    } evict_state_e;

    typedef struct packed {
        logic [LINE_W-1:0]       data;
        logic [VCTAG_LENGTH-1:0] tag;
        logic                    dirty;
    } evict_entry_t;

    function automatic logic [ADDR_LENGTH-1:0] line_addr(input logic [VCTAG_LENGTH-1:0] tag);
        return {tag, LINE_OFFSET'(0)};
    endfunction

endpackage

// File: rtl/l1_evict_buffer_if.sv
// rtl/l1_evict_buffer_if.sv - eviction, victim-cache fill, L2 writeback and lookup signals
interface l1_evict_buffer_if;
    import l1_evict_buffer_pkg::*;

    logic                    evict_valid;
    logic                    evict_ready;
    logic [LINE_W-1:0]       evict_data;
    logic [VCTAG_LENGTH-1:0] evict_tag;
    logic                    evict_dirty;
    logic                    vc_wen;
    logic [LINE_W-1:0]       vc_data;
    logic [VCTAG_LENGTH-1:0] vc_tag;
    logic                    wb_req;
    logic                    wb_ack;
    logic [ADDR_LENGTH-1:0]  wb_addr;
    logic [LINE_W-1:0]       wb_data;
    logic [ADDR_LENGTH-1:0]  lookup_addr;
    logic                    buf_hit;
    logic [DATA_LENGTH-1:0]  buf_data;
    logic                    empty;

    modport master (
        output evict_valid, evict_data, evict_tag, evict_dirty, wb_ack, lookup_addr,
        input  evict_ready, vc_wen, vc_data, vc_tag, wb_req, wb_addr, wb_data,
               buf_hit, buf_data, empty
    );

    modport slave (
        input  evict_valid, evict_data, evict_tag, evict_dirty, wb_ack, lookup_addr,
        output evict_ready, vc_wen, vc_data, vc_tag, wb_req, wb_addr, wb_data,
               buf_hit, buf_data, empty
    );

endinterface

// File: rtl/Configurable_Multiplexer.sv
// rtl/Configurable_Multiplexer.sv - N-way word select; only elaborated when EVICT_BUF_FWD_EN is defined
`ifdef EVICT_BUF_FWD_EN
module Configurable_Multiplexer #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [$clog2(N)-1:0] sel,
    input  logic [N*W-1:0]       din,
    output logic [W-1:0]         dout
);

    assign dout = din[sel*W +: W];

endmodule
`endif

// File: rtl/l1_evict_buffer_fifo.sv
// rtl/l1_evict_buffer_fifo.sv - evict_buffer_fifo: entry FIFO with occupancy and oldest-first view of all slots
module evict_buffer_fifo
    import l1_evict_buffer_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                                 clk_l1,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  evict_entry_t                         push_entry,
    input  logic                                 pop,
    output evict_entry_t                         head,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH):0]               count,
    output logic [DEPTH-1:0][VCTAG_LENGTH-1:0]   age_tag,
    output logic [DEPTH-1:0][LINE_W-1:0]         age_data,
    output logic [DEPTH-1:0]                     age_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    evict_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // payload needs no reset: occupancy alone decides what is live
    always_ff @(posedge clk_l1) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // index 0 is the oldest entry, so later slots are younger
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_tag[i]   = mem[rd_ptr + PW'(i)].tag;
            age_data[i]  = mem[rd_ptr + PW'(i)].data;
            age_valid[i] = (CW'(i) < count);
        end
    end

endmodule

// File: rtl/l1_evict_buffer.sv
// rtl/l1_evict_buffer.sv - L1 eviction queue draining to victim cache with L2 writeback; EVICT_BUF_FWD_EN enables lookup forwarding
module l1_evict_buffer
    import l1_evict_buffer_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic               clk_l1,
    input  logic               rst_n,
    l1_evict_buffer_if.slave   bus
);

    evict_state_e state;
    evict_state_e state_nxt;
    evict_entry_t push_entry;
    evict_entry_t head;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         wb_req_d;
    logic         vc_wen_d;

    assign push_entry = '{data: bus.evict_data, tag: bus.evict_tag, dirty: bus.evict_dirty};
    assign push       = bus.evict_valid && !fifo_full;

`ifdef EVICT_BUF_FWD_EN
    logic [DEPTH-1:0][VCTAG_LENGTH-1:0] age_tag;
    logic [DEPTH-1:0][LINE_W-1:0]       age_data;
    logic [DEPTH-1:0]                   age_valid;
`endif

    evict_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_l1     (clk_l1),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (),
`ifdef EVICT_BUF_FWD_EN
        .age_tag    (age_tag),
        .age_data   (age_data),
        .age_valid  (age_valid)
`else
        .age_tag    (),
        .age_data   (),
        .age_valid  ()
`endif
    );

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = head.dirty ? WB_REQ : VC_FILL;
            WB_REQ:  if (bus.wb_ack) state_nxt = VC_FILL;
            VC_FILL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // strobes decode from state only, so reset drops them without waiting for a clock
    always_comb begin
        wb_req_d = 1'b0;
        vc_wen_d = 1'b0;
        pop      = 1'b0;
        case (state)
            WB_REQ:  wb_req_d = 1'b1;
            VC_FILL: begin
                vc_wen_d = 1'b1;
                pop      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.evict_ready = !fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.wb_req      = wb_req_d;
    assign bus.wb_addr     = line_addr(head.tag);
    assign bus.wb_data     = head.data;
    assign bus.vc_wen      = vc_wen_d;
    assign bus.vc_tag      = head.tag;
    assign bus.vc_data     = head.data;

`ifdef EVICT_BUF_FWD_EN
    logic [VCTAG_LENGTH-1:0]   lookup_tag;
    logic [$clog2(SLOT)-1:0]   word_sel;
    logic                      fwd_hit;
    logic [LINE_W-1:0]         fwd_line;
    wire                       unused_lookup = ^bus.lookup_addr[LINE_OFFSET-1:0];

    assign lookup_tag = bus.lookup_addr[ADDR_LENGTH-1:LINE_OFFSET];
    assign word_sel   = bus.lookup_addr[LINE_OFFSET +: $clog2(SLOT)];

    // walk oldest to youngest so the youngest duplicate tag wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_line = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_valid[i] && (age_tag[i] == lookup_tag)) begin
                fwd_hit  = 1'b1;
                fwd_line = age_data[i];
            end
        end
    end

    Configurable_Multiplexer #(.N(SLOT), .W(DATA_LENGTH)) u_word_mux (
        .sel  (word_sel),
        .din  (fwd_line),
        .dout (bus.buf_data)
    );

    assign bus.buf_hit = fwd_hit;
`else
    wire unused_lookup = ^bus.lookup_addr;

    assign bus.buf_hit  = 1'b0;
    assign bus.buf_data = '0;
`endif

endmodule

// File: tb/tb_l1_evict_buffer.sv
// tb/tb_l1_evict_buffer.sv - self-checking bench: vector table, fill/stall, random queue model, mid-op reset
module tb_l1_evict_buffer;

    typedef struct packed {
        logic [25:0]  tag;
        logic         dirty;
        logic [127:0] data;
    } line_t;

    typedef struct {
        logic [25:0]  tag;
        logic         dirty;
        logic [127:0] data;
        int           ack_delay;
        bit           stray_ack;
        int           exp_vc_cycle;
        int           exp_wb_cycles;
        logic [31:0]  exp_wb_addr;
    } vec_t;

    logic clk_l1 = 1'b0;
    logic rst_n  = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    line_t model[$];
    line_t exp_q[$];
    vec_t  vecs[5];
    line_t fl[5];

    always #5 clk_l1 = ~clk_l1;

    l1_evict_buffer_if bus();

    l1_evict_buffer dut (
        .clk_l1 (clk_l1),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input line_t l);
        bus.evict_valid = 1'b1;
        bus.evict_tag   = l.tag;
        bus.evict_dirty = l.dirty;
        bus.evict_data  = l.data;
    endtask

    function automatic line_t rand_line();
        line_t l;
        l.tag   = 26'h2A0 + 26'($urandom_range(0, 5));
        l.dirty = 1'($urandom_range(0, 1));
        l.data  = {$urandom, $urandom, $urandom, $urandom};
        return l;
    endfunction

`ifdef EVICT_BUF_FWD_EN
    function automatic void fwd_model(input logic [31:0] la, output logic hit, output logic [31:0] w);
        hit = 1'b0;
        w   = '0;
        foreach (model[k]) begin
            if (model[k].tag == la[31:6]) begin
                hit = 1'b1;
                w   = model[k].data[la[7:6]*32 +: 32];
            end
        end
    endfunction
`endif

    task automatic drain();
        for (int c = 0; c < 40; c++) begin
            if (bus.vc_wen) begin
                if (exp_q.size() == 0) begin
                    chk("drain_extra_vc_wen", 1'b1, 1'b0);
                end else begin
                    chk("drain_tag", bus.vc_tag, exp_q[0].tag);
                    chk("drain_data", bus.vc_data, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            bus.wb_ack = bus.wb_req;
            @(negedge clk_l1);
        end
        bus.wb_ack = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_empty", bus.empty, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{26'h0ABCDEF, 1'b0, 128'h0123456789ABCDEFFEDCBA9876543210, 0, 1'b0, 2, 0, 32'h0};
        vecs[1] = '{26'h0001234, 1'b1, 128'h11112222333344445555666677778888, 5, 1'b0, 8, 6, 32'h00048D00};
        vecs[2] = '{26'h3FFFFFF, 1'b1, 128'hFFFFFFFF00000000AAAAAAAA55555555, 0, 1'b0, 3, 1, 32'hFFFFFFC0};
        vecs[3] = '{26'h0000000, 1'b1, 128'hC0FFEE00C0FFEE01C0FFEE02C0FFEE03, 2, 1'b0, 5, 3, 32'h0};
        vecs[4] = '{26'h2AAAAAA, 1'b0, 128'h5A5A5A5AA5A5A5A50F0F0F0FF0F0F0F0, 0, 1'b1, 2, 0, 32'h0};

        fl[0] = '{26'h1ABCDE2, 1'b1, {32'hA3A3A3A3, 32'hDEADBEEF, 32'hA1A1A1A1, 32'hA0A0A0A0}};
        fl[1] = '{26'h0000100, 1'b0, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}};
        fl[2] = '{26'h1ABCDE2, 1'b0, {32'hC3C3C3C3, 32'hCAFEF00D, 32'hC1C1C1C1, 32'hC0C0C0C0}};
        fl[3] = '{26'h0000101, 1'b0, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0}};
        fl[4] = '{26'h0000102, 1'b0, {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0}};

        bus.evict_valid = 1'b0;
        bus.evict_tag   = '0;
        bus.evict_dirty = 1'b0;
        bus.evict_data  = '0;
        bus.wb_ack      = 1'b0;
        bus.lookup_addr = '0;

        // reset state
        repeat (3) @(negedge clk_l1);
        chk("rst_evict_ready", bus.evict_ready, 1'b1);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_vc_wen", bus.vc_wen, 1'b0);
        chk("rst_wb_req", bus.wb_req, 1'b0);
        chk("rst_buf_hit", bus.buf_hit, 1'b0);
        rst_n = 1'b1;
        @(negedge clk_l1);

        // single-line table: latency, writeback hold, victim fill contents
        for (int v = 0; v < 5; v++) begin
            int           vc_cyc;
            int           vc_n;
            int           wb_n;
            int           wb_bad;
            logic [25:0]  got_tag;
            logic [127:0] got_data;
            vc_cyc = -1; vc_n = 0; wb_n = 0; wb_bad = 0; got_tag = '0; got_data = '0;
            drive('{vecs[v].tag, vecs[v].dirty, vecs[v].data});
            bus.wb_ack = vecs[v].stray_ack;
            @(negedge clk_l1);
            bus.evict_valid = 1'b0;
            chk($sformatf("v%0d_empty_after_push", v), bus.empty, 1'b0);
            for (int c = 1; c <= 20; c++) begin
                if (bus.vc_wen) begin
                    vc_n++;
                    if (vc_cyc < 0) begin
                        vc_cyc   = c;
                        got_tag  = bus.vc_tag;
                        got_data = bus.vc_data;
                    end
                end
                if (bus.wb_req) begin
                    wb_n++;
                    if (bus.wb_addr !== vecs[v].exp_wb_addr || bus.wb_data !== vecs[v].data) wb_bad++;
                end
                bus.wb_ack = vecs[v].stray_ack || (bus.wb_req && wb_n == vecs[v].ack_delay + 1);
                @(negedge clk_l1);
            end
            bus.wb_ack = 1'b0;
            chk($sformatf("v%0d_vc_cycle", v), 32'(vc_cyc), 32'(vecs[v].exp_vc_cycle));
            chk($sformatf("v%0d_vc_pulses", v), 32'(vc_n), 32'd1);
            chk($sformatf("v%0d_wb_cycles", v), 32'(wb_n), 32'(vecs[v].exp_wb_cycles));
            chk($sformatf("v%0d_wb_addr_data_bad", v), 32'(wb_bad), 32'd0);
            chk($sformatf("v%0d_vc_tag", v), got_tag, vecs[v].tag);
            chk($sformatf("v%0d_vc_data", v), got_data, vecs[v].data);
            chk($sformatf("v%0d_empty_end", v), bus.empty, 1'b1);
        end

        // fill to full behind a stalled writeback, then a 5th offer waits
        bus.wb_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_ready%0d", i), bus.evict_ready, 1'b1);
            drive(fl[i]);
            @(negedge clk_l1);
            if (i == 0) begin
                bus.lookup_addr = {fl[0].tag, 6'b0};
                #1;
`ifdef EVICT_BUF_FWD_EN
                chk("fwd_hit_single", bus.buf_hit, 1'b1);
                chk("fwd_data_single", bus.buf_data, 32'hDEADBEEF);
`else
                chk("nofwd_hit", bus.buf_hit, 1'b0);
                chk("nofwd_data", bus.buf_data, 32'h0);
`endif
            end
        end
        chk("full_ready", bus.evict_ready, 1'b0);
        drive(fl[4]);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_ready%0d", i), bus.evict_ready, 1'b0);
            chk($sformatf("stall_wb_req%0d", i), bus.wb_req, 1'b1);
            chk($sformatf("stall_vc_wen%0d", i), bus.vc_wen, 1'b0);
            @(negedge clk_l1);
        end
`ifdef EVICT_BUF_FWD_EN
        chk("fwd_hit_dup", bus.buf_hit, 1'b1);
        chk("fwd_data_youngest", bus.buf_data, 32'hCAFEF00D);
        bus.lookup_addr = {26'h3000000, 6'b0};
        #1;
        chk("fwd_miss", bus.buf_hit, 1'b0);
        bus.lookup_addr = {fl[0].tag, 6'b0};
`endif
        bus.wb_ack = 1'b1;
        @(negedge clk_l1);
        bus.wb_ack = 1'b0;
        chk("fill_vc_wen0", bus.vc_wen, 1'b1);
        chk("fill_vc_tag0", bus.vc_tag, fl[0].tag);
        chk("fill_vc_data0", bus.vc_data, fl[0].data);
        chk("pop_cycle_ready", bus.evict_ready, 1'b0);
`ifdef EVICT_BUF_FWD_EN
        chk("fwd_hit_popping", bus.buf_hit, 1'b1);
`endif
        @(negedge clk_l1);
        chk("after_pop_ready", bus.evict_ready, 1'b1);
        @(negedge clk_l1);
        bus.evict_valid = 1'b0;
        chk("refull_ready", bus.evict_ready, 1'b0);
        exp_q = {fl[1], fl[2], fl[3], fl[4]};
        drain();

        // random traffic against an in-order queue model
        begin
            bit    wb_done;
            bit    exp_ready;
            line_t l;
            wb_done = 1'b0;
            for (int c = 0; c < 900; c++) begin
                @(negedge clk_l1);
                exp_ready = (model.size() < 4);
                chk("rnd_ready", bus.evict_ready, exp_ready);
                chk("rnd_empty", bus.empty, model.size() == 0);
`ifdef EVICT_BUF_FWD_EN
                begin
                    logic        eh;
                    logic [31:0] ew;
                    fwd_model(bus.lookup_addr, eh, ew);
                    chk("rnd_buf_hit", bus.buf_hit, eh);
                    if (eh) chk("rnd_buf_data", bus.buf_data, ew);
                end
`else
                chk("rnd_buf_hit_off", bus.buf_hit, 1'b0);
`endif
                if (bus.wb_req) begin
                    if (model.size() == 0) chk("rnd_wb_req_when_empty", 1'b1, 1'b0);
                    else begin
                        chk("rnd_wb_addr", bus.wb_addr, {model[0].tag, 6'b0});
                        chk("rnd_wb_data", bus.wb_data, model[0].data);
                        chk("rnd_wb_dirty", model[0].dirty, 1'b1);
                    end
                end
                bus.wb_ack = (c >= 800) ? 1'b1 : ($urandom_range(0, 2) == 0);
                if (bus.vc_wen) begin
                    if (model.size() == 0) chk("rnd_vc_when_empty", 1'b1, 1'b0);
                    else begin
                        chk("rnd_vc_tag", bus.vc_tag, model[0].tag);
                        chk("rnd_vc_data", bus.vc_data, model[0].data);
                        chk("rnd_vc_wb_done", wb_done, model[0].dirty);
                        void'(model.pop_front());
                    end
                    wb_done = 1'b0;
                end else if (bus.wb_req && bus.wb_ack) begin
                    wb_done = 1'b1;
                end
                if (c < 800 && $urandom_range(0, 1) == 1) begin
                    l = rand_line();
                    drive(l);
                    if (exp_ready) model.push_back(l);
                end else begin
                    bus.evict_valid = 1'b0;
                end
                if ($urandom_range(0, 1) == 1)
                    bus.lookup_addr = {26'h2A0 + 26'($urandom_range(0, 5)), 6'($urandom)};
                else
                    bus.lookup_addr = $urandom;
            end
            bus.wb_ack = 1'b0;
            @(negedge clk_l1);
            chk("rnd_model_drained", 32'(model.size()), 32'd0);
            chk("rnd_empty_final", bus.empty, 1'b1);
        end

        // reset while a writeback is pending
        begin
            int vc_seen;
            int wb_seen;
            vc_seen = 0;
            wb_seen = 0;
            drive('{26'h0000055, 1'b1, 128'h5});
            @(negedge clk_l1);
            bus.evict_valid = 1'b0;
            @(negedge clk_l1);
            chk("mid_rst_wb_req_before", bus.wb_req, 1'b1);
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst_wb_req", bus.wb_req, 1'b0);
            chk("mid_rst_vc_wen", bus.vc_wen, 1'b0);
            chk("mid_rst_empty", bus.empty, 1'b1);
            chk("mid_rst_ready", bus.evict_ready, 1'b1);
            @(negedge clk_l1);
            rst_n = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk_l1);
                if (bus.vc_wen) vc_seen++;
                if (bus.wb_req) wb_seen++;
            end
            chk("post_rst_vc_wen_count", 32'(vc_seen), 32'd0);
            chk("post_rst_wb_req_count", 32'(wb_seen), 32'd0);
            chk("post_rst_empty", bus.empty, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
